// File: rtl/functional_unit_collector.sv
// Collects results from N functional units through per-unit FIFOs and round-robin arbitrates them into one registered writeback port.
// Two-cycle latency from push to writeback; each unit stalls only on its own full FIFO, and the output register holds its entry under writeback backpressure.

// Generic circular-buffer FIFO; occupancy counter gives cheap full/empty flags.
module fu_collector_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en, pop_en;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CNT_FULL);
    assign push_en    = push_vld_i && !full_o;
    assign pop_en     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en && !pop_en) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop_en && !push_en) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

module functional_unit_collector #(
    parameter int FUNCTIONAL_UNIT_INPUT_BUS_WIDTH = 4,
    parameter int DATA_WIDTH                      = 32,
    parameter int TAG_WIDTH                       = 5,
    parameter int FIFO_DEPTH                      = 2
) (
    input  logic                                                            clock,
    input  logic                                                            reset,
    input  logic [FUNCTIONAL_UNIT_INPUT_BUS_WIDTH-1:0]                      fu_result_valid,
    input  logic [FUNCTIONAL_UNIT_INPUT_BUS_WIDTH-1:0][DATA_WIDTH-1:0]      fu_result_data,
    input  logic [FUNCTIONAL_UNIT_INPUT_BUS_WIDTH-1:0][TAG_WIDTH-1:0]       fu_result_tag,
    output logic [FUNCTIONAL_UNIT_INPUT_BUS_WIDTH-1:0]                      fu_result_ready,
    output logic                                                            writeback_valid,
    output logic [DATA_WIDTH-1:0]                                           writeback_data,
    output logic [TAG_WIDTH-1:0]                                            writeback_tag,
    output logic [$clog2(FUNCTIONAL_UNIT_INPUT_BUS_WIDTH)-1:0]              writeback_functional_unit_id,
    input  logic                                                            writeback_ready
);
    localparam int N   = FUNCTIONAL_UNIT_INPUT_BUS_WIDTH;
    localparam int IDW = $clog2(N);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    logic [N-1:0]   fifo_empty, fifo_full, fifo_pop;
    entry_t [N-1:0] fifo_head;

    logic [IDW-1:0] ptr_q, ptr_d, win;
    logic           found, load_en, grant;

    logic           wb_vld_q, wb_vld_d;
    entry_t         wb_dat_q, wb_dat_d;
    logic [IDW-1:0] wb_id_q, wb_id_d;

    for (genvar g = 0; g < N; g++) begin : g_fifo
        entry_t push_dat;
        assign push_dat = '{data: fu_result_data[g], tag: fu_result_tag[g]};

        fu_collector_fifo #(
            .WIDTH (DATA_WIDTH + TAG_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .push_vld_i (fu_result_valid[g]),
            .push_dat_i (push_dat),
            .pop_i      (fifo_pop[g]),
            .head_dat_o (fifo_head[g]),
            .empty_o    (fifo_empty[g]),
            .full_o     (fifo_full[g])
        );
    end

    // Ready comes from registered occupancy only, so it never depends on valid.
    assign fu_result_ready = ~fifo_full;

    // Round-robin search: first non-empty FIFO at or above the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && !fifo_empty[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign load_en = !wb_vld_q || writeback_ready;
    assign grant   = load_en && found;

    always_comb begin
        fifo_pop = '0;
        ptr_d    = ptr_q;
        wb_vld_d = wb_vld_q;
        wb_dat_d = wb_dat_q;
        wb_id_d  = wb_id_q;
        for (int i = 0; i < N; i++) begin
            fifo_pop[i] = grant && (win == IDW'(i));
        end
        if (grant) begin
            ptr_d    = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
            wb_dat_d = fifo_head[win];
            wb_id_d  = win;
        end
        if (load_en) begin
            wb_vld_d = found;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            wb_vld_q <= 1'b0;
            wb_dat_q <= '0;
            wb_id_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wb_vld_q <= wb_vld_d;
            wb_dat_q <= wb_dat_d;
            wb_id_q  <= wb_id_d;
        end
    end

    assign writeback_valid              = wb_vld_q;
    assign writeback_data               = wb_dat_q.data;
    assign writeback_tag                = wb_dat_q.tag;
    assign writeback_functional_unit_id = wb_id_q;
endmodule

// File: tb/tb_functional_unit_collector.sv
// Directed bench with a scoreboard queue of expected writebacks and a separate monitor.
module tb_functional_unit_collector;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 5;

    typedef struct packed {
        logic [1:0]    id;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic [N-1:0]             fu_result_valid;
    logic [N-1:0][DW-1:0]     fu_result_data;
    logic [N-1:0][TW-1:0]     fu_result_tag;
    logic [N-1:0]             fu_result_ready;
    logic                     writeback_valid;
    logic [DW-1:0]            writeback_data;
    logic [TW-1:0]            writeback_tag;
    logic [1:0]               writeback_functional_unit_id;
    logic                     writeback_ready;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    functional_unit_collector #(
        .FUNCTIONAL_UNIT_INPUT_BUS_WIDTH (N),
        .DATA_WIDTH                      (DW),
        .TAG_WIDTH                       (TW),
        .FIFO_DEPTH                      (2)
    ) dut (
        .clock                        (clock),
        .reset                        (reset),
        .fu_result_valid              (fu_result_valid),
        .fu_result_data               (fu_result_data),
        .fu_result_tag                (fu_result_tag),
        .fu_result_ready              (fu_result_ready),
        .writeback_valid              (writeback_valid),
        .writeback_data               (writeback_data),
        .writeback_tag                (writeback_tag),
        .writeback_functional_unit_id (writeback_functional_unit_id),
        .writeback_ready              (writeback_ready)
    );

    initial begin
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        sb.push_back({id, tag, data});
    endtask

    task automatic do_reset();
        fu_result_valid = '0;
        writeback_ready = 1'b0;
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40; c++) begin
            if (sb.size() == 0 && !writeback_valid) break;
            tick();
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every handshake on the writeback port must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && writeback_valid && writeback_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected actual=id%0d/tag%0h/data%0h required=no_entry",
                             writeback_functional_unit_id, writeback_tag, writeback_data);
                end else begin
                    checks--;
                    e = sb.pop_front();
                    chk("wb_entry", {writeback_functional_unit_id, writeback_tag, writeback_data}, e);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        bit           acc;
        int           i;
        bit           fu3_pend;

        fu_result_valid = '0;
        fu_result_data  = '0;
        fu_result_tag   = '0;
        writeback_ready = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst_valid", 64'(writeback_valid), 64'd0);
        chk("rst_data", 64'(writeback_data), 64'd0);
        chk("rst_tag", 64'(writeback_tag), 64'd0);
        chk("rst_id", 64'(writeback_functional_unit_id), 64'd0);
        chk("rst_ready", 64'(fu_result_ready), 64'hF);
        tick();
        tick();
        reset = 1'b0;
        chk("ready_after_reset", 64'(fu_result_ready), 64'hF);

        // Single result from FU2 under backpressure
        fu_result_valid    = 4'b0100;
        fu_result_data[2]  = 32'hDEADBEEF;
        fu_result_tag[2]   = 5'd7;
        push_exp(2'd2, 5'd7, 32'hDEADBEEF);
        tick();
        fu_result_valid = '0;
        chk("single_no_bypass", 64'(writeback_valid), 64'd0);
        tick();
        chk("single_valid", 64'(writeback_valid), 64'd1);
        chk("single_data", 64'(writeback_data), 64'hDEADBEEF);
        chk("single_tag", 64'(writeback_tag), 64'd7);
        chk("single_id", 64'(writeback_functional_unit_id), 64'd2);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_valid", 64'(writeback_valid), 64'd1);
            chk("hold_fields", {writeback_functional_unit_id, writeback_tag, writeback_data},
                {2'd2, 5'd7, 32'hDEADBEEF});
        end
        writeback_ready = 1'b1;
        tick();
        chk("single_consumed", 64'(writeback_valid), 64'd0);

        // All four units push on the same edge
        do_reset();
        writeback_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            fu_result_data[k] = 32'h1000_0000 + 32'(k);
            fu_result_tag[k]  = 5'(10 + k);
            push_exp(2'(k), 5'(10 + k), 32'h1000_0000 + 32'(k));
        end
        fu_result_valid = 4'hF;
        tick();
        fu_result_valid = '0;
        chk("simul_no_bypass", 64'(writeback_valid), 64'd0);
        for (int k = 0; k < N; k++) begin
            tick();
            chk("simul_valid", 64'(writeback_valid), 64'd1);
            chk("simul_id", 64'(writeback_functional_unit_id), 64'(k));
        end
        tick();
        chk("simul_idle", 64'(writeback_valid), 64'd0);

        // Backpressure on FU1: A,B,C accepted, D stalls until writeback drains
        writeback_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_exp(2'd1, 5'(20 + k), 32'hA000_0000 + 32'(k));
        end
        fu_result_valid[1] = 1'b1;
        fu_result_data[1]  = 32'hA000_0000;
        fu_result_tag[1]   = 5'd20;
        tick();
        chk("bp_ready_e1", 64'(fu_result_ready[1]), 64'd1);
        fu_result_data[1] = 32'hA000_0001;
        fu_result_tag[1]  = 5'd21;
        tick();
        chk("bp_ready_e2", 64'(fu_result_ready[1]), 64'd1);
        chk("bp_wb_a", 64'(writeback_data), 64'hA000_0000);
        fu_result_data[1] = 32'hA000_0002;
        fu_result_tag[1]  = 5'd22;
        tick();
        chk("bp_full_e3", 64'(fu_result_ready[1]), 64'd0);
        fu_result_data[1] = 32'hA000_0003;
        fu_result_tag[1]  = 5'd23;
        tick();
        tick();
        chk("bp_still_full", 64'(fu_result_ready[1]), 64'd0);
        chk("bp_hold_a", 64'(writeback_data), 64'hA000_0000);
        writeback_ready = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) begin
            r = fu_result_ready;
            tick();
            acc = r[1];
        end
        fu_result_valid[1] = 1'b0;
        chk("bp_d_accepted", 64'(acc), 64'd1);
        drain("bp_drain");

        // Fairness: FU0 streams continuously, FU3's single result goes second
        do_reset();
        writeback_ready = 1'b1;
        push_exp(2'd0, 5'd1, 32'h5000_0000);
        push_exp(2'd3, 5'd31, 32'h3333_3333);
        for (int k = 1; k < 6; k++) begin
            push_exp(2'd0, 5'(1 + k), 32'h5000_0000 + 32'(k));
        end
        fu_result_data[3] = 32'h3333_3333;
        fu_result_tag[3]  = 5'd31;
        fu3_pend = 1'b1;
        i = 0;
        for (int c = 0; c < 60 && i < 6; c++) begin
            fu_result_valid[0] = 1'b1;
            fu_result_data[0]  = 32'h5000_0000 + 32'(i);
            fu_result_tag[0]   = 5'(1 + i);
            fu_result_valid[3] = fu3_pend;
            r = fu_result_ready;
            tick();
            if (r[0]) i++;
            if (r[3]) fu3_pend = 1'b0;
        end
        fu_result_valid = '0;
        chk("fair_fu0_sent", 64'(i), 64'd6);
        drain("fair_drain");

        // Reset mid-operation discards everything buffered
        writeback_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            fu_result_data[k] = 32'h7700_0000 + 32'(k);
            fu_result_tag[k]  = 5'(k + 3);
        end
        fu_result_valid = 4'hF;
        tick();
        fu_result_valid = '0;
        tick();
        chk("mid_pre_valid", 64'(writeback_valid), 64'd1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(writeback_valid), 64'd0);
        chk("mid_rst_fields", {writeback_functional_unit_id, writeback_tag, writeback_data}, 64'd0);
        chk("mid_rst_ready", 64'(fu_result_ready), 64'hF);
        tick();
        reset = 1'b0;
        writeback_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("mid_no_stale", 64'(writeback_valid), 64'd0);
        end

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/functional_unit_collector.md
FUNCTIONAL_UNIT_COLLECTOR -- requirements
Module: functional_unit_collector

Interface
REQ-001 SHALL have parameter FUNCTIONAL_UNIT_INPUT_BUS_WIDTH, default 4, giving the number of functional units (N) whose results are collected.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the result data width.
REQ-003 SHALL have parameter TAG_WIDTH, default 5, giving the destination-register tag width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, giving per-unit buffer entries; legal values are powers of two >= 2.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port fu_result_valid, input, [N-1:0]: unit i presents a result.
REQ-008 SHALL have port fu_result_data, input, [N-1:0][DATA_WIDTH-1:0]: per-unit result data.
REQ-009 SHALL have port fu_result_tag, input, [N-1:0][TAG_WIDTH-1:0]: per-unit destination tag.
REQ-010 SHALL have port fu_result_ready, output, [N-1:0]: unit i's buffer can accept an entry.
REQ-011 SHALL have port writeback_valid, output, 1 bit: writeback entry valid.
REQ-012 SHALL have port writeback_data, output, [DATA_WIDTH-1:0]: writeback data.
REQ-013 SHALL have port writeback_tag, output, [TAG_WIDTH-1:0]: writeback destination tag.
REQ-014 SHALL have port writeback_functional_unit_id, output, [$clog2(N)-1:0]: source unit index.
REQ-015 SHALL have port writeback_ready, input, 1 bit: consumer accepts the writeback entry.

Function
REQ-016 SHALL drive fu_result_ready[i] high exactly when FIFO i is not full, derived from registered state only, never from fu_result_valid.
REQ-017 SHALL push {data, tag} into FIFO i on an edge where fu_result_valid[i] and fu_result_ready[i] are both high; all N units may push in the same cycle.
REQ-018 SHALL allow push and pop on the same FIFO in the same cycle when it is not full, leaving occupancy unchanged.
REQ-019 SHALL hold the writeback entry in an output register that loads when it is empty or is being consumed (writeback_valid and writeback_ready) in that cycle.
REQ-020 SHALL choose the loaded entry by round-robin over non-empty FIFOs, searching from a priority pointer upward with wrap-around from N-1 to 0.
REQ-021 SHALL set the priority pointer to (winner+1) mod N on each grant and leave it unchanged when no grant occurs.
REQ-022 SHALL present an entry pushed on edge k at the writeback outputs no earlier than after edge k+1 (no input-to-output bypass).
REQ-023 SHALL sustain one writeback per cycle while writeback_ready is high and any FIFO is non-empty.
REQ-024 SHALL keep writeback_data, writeback_tag and writeback_functional_unit_id stable while writeback_valid is high and writeback_ready is low.
REQ-025 SHALL preserve per-unit order; no ordering guarantee across units.
REQ-026 SHALL grant any non-empty FIFO within N consecutive grants.
REQ-027 SHALL never drop or duplicate an accepted entry.

Reset
REQ-028 SHALL, while reset is high, immediately empty all FIFOs, clear the priority pointer to 0 and drive writeback_valid, writeback_data, writeback_tag and writeback_functional_unit_id to 0.
REQ-029 SHALL drive fu_result_ready to all ones while in reset and immediately after reset.
REQ-030 SHALL discard all buffered and in-flight entries when reset asserts mid-operation.

Verification
REQ-031 Reset: assert reset -> writeback_valid=0, all writeback fields 0, fu_result_ready=4'b1111.
REQ-032 Single result: FU2 pushes data 0xDEADBEEF, tag 7 on edge 1, writeback_ready=0 -> after edge 2 writeback_valid=1, data 0xDEADBEEF, tag 7, id 2, held stable for 3 cycles; writeback_ready=1 -> writeback_valid=0 after the next edge.
REQ-033 Simultaneous: after reset, FU0..FU3 each push one result on the same edge, writeback_ready=1 -> ids 0,1,2,3 appear on four consecutive cycles.
REQ-034 Backpressure: writeback_ready=0, FU1 valid with A,B,C,D on consecutive cycles -> A,B,C accepted, fu_result_ready[1]=0 from edge 3; then writeback_ready=1 -> A,B,C,D written back in order.
REQ-035 Fairness: FU0 continuously valid, FU3 pushes one result, writeback_ready=1 -> FU3's result written back within 4 writeback cycles.
REQ-036 Reset mid-operation: with 3 entries buffered and writeback_valid=1, assert reset -> writeback_valid=0 without a clock edge; after release no stale entry appears.
